// File: rtl/gpio_io_ctrl.sv
// GPIO pad controller: registered pad drive, input sync,
// per-pin debounce, edge detect and sticky maskable irq status.
module gpio_io_ctrl #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      SYNC_STAGES  = 2,
  parameter int unsigned      DEBOUNCE_W   = 16,
  parameter logic [WIDTH-1:0] IN_RESET_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WIDTH-1:0]      gpio_out_i,
  input  logic [WIDTH-1:0]      gpio_oe_i,
  input  logic [WIDTH-1:0]      gpio_od_i,
  input  logic [WIDTH-1:0]      pad_in_i,
  output logic [WIDTH-1:0]      pad_out_o,
  output logic [WIDTH-1:0]      pad_oe_o,
  input  logic [WIDTH-1:0]      deb_en_i,
  input  logic [DEBOUNCE_W-1:0] debounce_limit_i,
  input  logic [WIDTH-1:0]      rise_en_i,
  input  logic [WIDTH-1:0]      fall_en_i,
  input  logic [WIDTH-1:0]      irq_clr_i,
  output logic [WIDTH-1:0]      gpio_in_o,
  output logic [WIDTH-1:0]      irq_status_o,
  output logic                  irq_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set;
  logic             lim_zero;

  // Open-drain pins never drive high: release instead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_out_o <= '0;
      pad_oe_o  <= '0;
    end else begin
      pad_out_o <= gpio_out_i & ~gpio_od_i;
      pad_oe_o  <= gpio_oe_i & ~(gpio_od_i & gpio_out_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= IN_RESET_VAL;
      end
    end else begin
      sync_q[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign lim_zero = (debounce_limit_i == '0);

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    logic [DEBOUNCE_W-1:0] cnt_q;
    logic [DEBOUNCE_W-1:0] cnt_d;
    logic [DEBOUNCE_W:0]   lim;
    logic [DEBOUNCE_W:0]   inc;
    logic                  upd_b;

    // Limit 0 or bypass both mean "accept on the first differing cycle".
    always_comb begin
      lim   = {1'b0, debounce_limit_i};
      if (!deb_en_i[g] || lim_zero) begin
        lim = (DEBOUNCE_W+1)'(1);
      end
      inc   = {1'b0, cnt_q} + (DEBOUNCE_W+1)'(1);
      upd_b = 1'b0;
      cnt_d = cnt_q;
      if (sync[g] == gpio_in_o[g]) begin
        cnt_d = '0;
      end else if (inc >= lim) begin
        upd_b = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = inc[DEBOUNCE_W-1:0];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign upd[g] = upd_b;
  end

  assign rise = upd & sync;
  assign fall = upd & ~sync;
  assign set  = (rise & rise_en_i) | (fall & fall_en_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_in_o <= IN_RESET_VAL;
    end else begin
      gpio_in_o <= (gpio_in_o & ~upd) | (sync & upd);
    end
  end

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_status_o <= '0;
      irq_o        <= 1'b0;
    end else begin
      irq_status_o <= (irq_status_o & ~irq_clr_i) | set;
      irq_o        <= |irq_status_o;
    end
  end

endmodule

// File: tb/tb_gpio_io_ctrl.sv
// Scoreboard bench for gpio_io_ctrl: reference model pushes
// expected outputs each edge, a negedge monitor compares.
module tb_gpio_io_ctrl;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DW = 8;
  localparam logic [W-1:0] RST = 8'h01;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [W-1:0]  gpio_out_i, gpio_oe_i, gpio_od_i, pad_in_i;
  logic [W-1:0]  pad_out_o, pad_oe_o;
  logic [W-1:0]  deb_en_i, rise_en_i, fall_en_i, irq_clr_i;
  logic [DW-1:0] debounce_limit_i;
  logic [W-1:0]  gpio_in_o, irq_status_o;
  logic          irq_o;

  gpio_io_ctrl #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_W(DW), .IN_RESET_VAL(RST)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .gpio_out_i(gpio_out_i), .gpio_oe_i(gpio_oe_i),
    .gpio_od_i(gpio_od_i), .pad_in_i(pad_in_i),
    .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o),
    .deb_en_i(deb_en_i), .debounce_limit_i(debounce_limit_i),
    .rise_en_i(rise_en_i), .fall_en_i(fall_en_i),
    .irq_clr_i(irq_clr_i), .gpio_in_o(gpio_in_o),
    .irq_status_o(irq_status_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] po, poe, gin, st;
    logic         irq;
  } exp_t;

  exp_t         expq[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the synchronised input is the pad sampled SS edges
  // ago; a pin's filtered level flips once the most recent L synced
  // samples all disagree with it.
  logic [W-1:0] syncq[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_po, m_poe, m_gin, m_st;
  logic         m_irq;

  initial begin
    logic [W-1:0] s, upd, setv;
    int           lim, run;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        m_po = '0; m_poe = '0; m_gin = RST; m_st = '0; m_irq = 1'b0;
        syncq.delete();
        hist.delete();
        for (int k = 0; k < SS; k++) syncq.push_back(RST);
      end else begin
        s = syncq.pop_front();
        syncq.push_back(pad_in_i);
        hist.push_back(s);
        if (hist.size() > 300) void'(hist.pop_front());
        upd = '0;
        for (int i = 0; i < W; i++) begin
          lim = (deb_en_i[i] && debounce_limit_i != 0)
                ? int'(debounce_limit_i) : 1;
          run = 0;
          for (int k = hist.size() - 1; k >= 0 && run < lim; k--) begin
            if (hist[k][i] != m_gin[i]) run++;
            else break;
          end
          if (run >= lim) upd[i] = 1'b1;
        end
        setv  = (upd & s & rise_en_i) | (upd & ~s & fall_en_i);
        m_irq = (m_st != 0);
        m_st  = (m_st & ~irq_clr_i) | setv;
        m_gin = m_gin ^ upd;
        for (int i = 0; i < W; i++) begin
          if (gpio_od_i[i]) begin
            m_po[i]  = 1'b0;
            m_poe[i] = gpio_oe_i[i] && !gpio_out_i[i];
          end else begin
            m_po[i]  = gpio_out_i[i];
            m_poe[i] = gpio_oe_i[i];
          end
        end
      end
      expq.push_back('{po: m_po, poe: m_poe, gin: m_gin,
                       st: m_st, irq: m_irq});
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pad_out", 32'(pad_out_o), 32'(e.po));
        chk("pad_oe", 32'(pad_oe_o), 32'(e.poe));
        chk("gpio_in", 32'(gpio_in_o), 32'(e.gin));
        chk("irq_status", 32'(irq_status_o), 32'(e.st));
        chk("irq", 32'(irq_o), 32'(e.irq));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic async_reset_check();
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_pad_out", 32'(pad_out_o), 32'h0);
    chk("async_rst_pad_oe", 32'(pad_oe_o), 32'h0);
    chk("async_rst_gpio_in", 32'(gpio_in_o), 32'(RST));
    chk("async_rst_status", 32'(irq_status_o), 32'h0);
    chk("async_rst_irq", 32'(irq_o), 32'h0);
    cyc(2);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    gpio_out_i = '0; gpio_oe_i = '0; gpio_od_i = '0;
    pad_in_i = 8'h01; deb_en_i = '0; debounce_limit_i = '0;
    rise_en_i = '1; fall_en_i = '1; irq_clr_i = '0;
    cyc(3);
    rst_ni = 1'b1;
    cyc(100);

    gpio_od_i = 8'h08; gpio_oe_i = 8'h0C; gpio_out_i = 8'h0C;
    cyc(2);
    gpio_out_i = 8'h00;
    cyc(2);
    for (int k = 0; k < 4; k++) begin
      gpio_out_i[2] = ~gpio_out_i[2];
      gpio_out_i[3] = k[0];
      cyc(1);
    end

    debounce_limit_i = 8'd5; deb_en_i = 8'h02;
    pad_in_i[1] = 1'b1; cyc(4);
    pad_in_i[1] = 1'b0; cyc(12);
    pad_in_i[1] = 1'b1; cyc(8);
    pad_in_i[1] = 1'b0; cyc(12);

    deb_en_i = 8'h00;
    pad_in_i[4] = 1'b1; cyc(6);
    irq_clr_i = 8'h12; cyc(1);
    irq_clr_i = 8'h00; cyc(3);
    pad_in_i[4] = 1'b0; cyc(2);
    irq_clr_i = 8'h10; cyc(1);
    irq_clr_i = 8'h00; cyc(1);
    irq_clr_i = 8'h10; cyc(1);
    irq_clr_i = 8'h00; cyc(4);

    debounce_limit_i = 8'd10; deb_en_i = 8'h20;
    pad_in_i[5] = 1'b1; cyc(5);
    async_reset_check();
    cyc(20);

    for (int n = 0; n < 2000; n++) begin
      pad_in_i   ^= W'($urandom & $urandom & $urandom);
      gpio_out_i = W'($urandom);
      gpio_oe_i  = W'($urandom);
      gpio_od_i  = W'($urandom);
      irq_clr_i  = W'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) begin
        debounce_limit_i = DW'($urandom_range(0, 6));
        deb_en_i  = W'($urandom);
        rise_en_i = W'($urandom);
        fall_en_i = W'($urandom);
      end
      if ($urandom_range(0, 399) == 0) async_reset_check();
      else cyc(1);
    end

    cyc(3);
    @(negedge clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
